// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye video DMA and the object engine:
// default object-table geometry, read latency and the DMA FSM encoding.
package jtpopeye_pkg;

  // Default object-table geometry, shared with the object engine
  localparam int DMA_AW   = 10;
  localparam int DMA_LEN  = 1024;
  // Registered address plus registered RAM output
  localparam int DMA_RDLY = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    REL   = 3'd4
  } dma_state_e;

endpackage

// File: rtl/jtpopeye_dma_pipe.sv
// DEPTH-stage {valid, addr} delay line. It tracks which address the data on a
// registered-RAM read port belongs to, DEPTH clocks after the address was issued.
module jtpopeye_dma_pipe #(
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] vld_r;
  logic [AW-1:0]    adr_r [DEPTH];

  // Shift the {valid, addr} pair one stage per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        adr_r[i] <= {AW{1'b0}};
      end
    end else begin
      vld_r[0] <= in_valid;
      adr_r[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i] <= vld_r[i-1];
        adr_r[i] <= adr_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_addr  = adr_r[DEPTH-1];

endmodule

// File: rtl/jtpopeye_dma.sv
// Main-CPU DMA bus master. On each VB rising edge it takes the Z80 bus,
// streams LEN bytes of the object table from main RAM into the object
// line buffer and hands the bus back. INITEO reports a pending/active copy.
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter int AW   = DMA_AW,
  parameter int LEN  = DMA_LEN,
  parameter int RDLY = DMA_RDLY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          VB,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic [AW-1:0] AD_DMA,
  output logic          dma_cs,
  input  logic [7:0]    DD_DMA,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          obj_we,
  output logic          INITEO,
  output logic          dma_done
);

  // Counter is one bit wider than the address so LEN = 2^AW never wraps
  localparam logic [AW:0]   LAST_CNT = (AW+1)'(LEN - 1);
  localparam int            DW       = (RDLY > 1) ? $clog2(RDLY) : 1;
  localparam logic [DW-1:0] LAST_DRN = DW'(RDLY - 1);

  dma_state_e    state_r;
  logic          vb_l_r;
  logic          vb_edge_s;
  logic [AW:0]   cnt_r;
  logic [DW-1:0] drn_r;
  logic          issue_s;
  logic          pipe_vld_s;
  logic [AW-1:0] pipe_addr_s;

  assign vb_edge_s = VB & ~vb_l_r;
  assign issue_s   = (state_r == XFER);
  assign AD_DMA    = cnt_r[AW-1:0];

  // Delayed copy of VB for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_l_r <= 1'b0;
    end else begin
      vb_l_r <= VB;
    end
  end

  // Bus request / transfer sequencer with its address and drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      busrq_n  <= 1'b1;
      dma_cs   <= 1'b0;
      INITEO   <= 1'b0;
      dma_done <= 1'b0;
      cnt_r    <= {(AW+1){1'b0}};
      drn_r    <= {DW{1'b0}};
    end else begin
      dma_done <= 1'b0;
      case (state_r)
        IDLE: begin
          // VB edges outside IDLE are dropped, never queued
          if (vb_edge_s) begin
            busrq_n <= 1'b0;
            INITEO  <= 1'b1;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (!busak_n) begin
            dma_cs  <= 1'b1;
            cnt_r   <= {(AW+1){1'b0}};
            state_r <= XFER;
          end
        end
        XFER: begin
          // Address holds at LEN-1 once the last byte is issued
          if (cnt_r == LAST_CNT) begin
            drn_r   <= {DW{1'b0}};
            state_r <= DRAIN;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DRAIN: begin
          // Keep the RAM mux on AD_DMA until the last read has landed
          if (drn_r == LAST_DRN) begin
            dma_cs  <= 1'b0;
            busrq_n <= 1'b1;
            state_r <= REL;
          end else begin
            drn_r <= drn_r + 1'b1;
          end
        end
        REL: begin
          if (busak_n) begin
            INITEO   <= 1'b0;
            dma_done <= 1'b1;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busrq_n <= 1'b1;
          dma_cs  <= 1'b0;
          INITEO  <= 1'b0;
        end
      endcase
    end
  end

  jtpopeye_dma_pipe #(
    .AW    (AW),
    .DEPTH (RDLY)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_s),
    .in_addr   (AD_DMA),
    .out_valid (pipe_vld_s),
    .out_addr  (pipe_addr_s)
  );

  // Write each byte leaving the read pipeline into the object buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obj_we   <= 1'b0;
      obj_addr <= {AW{1'b0}};
      obj_data <= 8'h00;
    end else begin
      obj_we <= pipe_vld_s;
      if (pipe_vld_s) begin
        obj_addr <= pipe_addr_s;
        obj_data <= DD_DMA;
      end else begin
        obj_addr <= obj_addr;
        obj_data <= obj_data;
      end
    end
  end

endmodule

// File: doc/jtpopeye_dma.md
Name: jtpopeye_dma

Overview:
- Bus-master side of the main-CPU DMA interface.
- Once per frame, on the rising edge of VB, it requests the Z80 bus and waits for the grant.
- It then drives AD_DMA / dma_cs to stream the object table out of main RAM (DD_DMA), writes each byte into the object line-buffer RAM, and releases the bus.
- Sits in the video section, between the main CPU block and the object engine; it also produces the INITEO status bit the CPU reads on I/O port 1.

Parameters:
- AW, 10, DMA address width; matches AD_DMA.
- LEN, 1024, number of bytes copied per frame (1..2^AW).
- RDLY, 2, clk cycles from AD_DMA/dma_cs change to valid DD_DMA (registered address + registered RAM output).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- VB  in  1  vertical blank, clk-synchronous level
- busrq_n  out  1  bus request to the CPU, active low
- busak_n  in  1  bus acknowledge from the CPU, active low; changes only on cpu_cen
- AD_DMA  out  AW  main RAM read address
- dma_cs  out  1  steers the main RAM address mux to AD_DMA
- DD_DMA  in  8  main RAM read data
- obj_addr  out  AW  object buffer write address
- obj_data  out  8  object buffer write data
- obj_we  out  1  object buffer write strobe, one clk per byte
- INITEO  out  1  high while a transfer is pending or in progress
- dma_done  out  1  one-clk pulse when the bus is released after a full copy

Behaviour:
- Reset values (async, immediate): busrq_n=1, dma_cs=0, AD_DMA=0, obj_we=0, obj_addr=0, obj_data=0, INITEO=0, dma_done=0, state=IDLE, VB edge register=0.
- VB rising edge: detected as VB & ~VB_l, registered each clk.
- IDLE:
  - On a VB rising edge: busrq_n<=0, INITEO<=1, go to REQ.
  - VB edges in any state other than IDLE are ignored; no queuing.
- REQ:
  - Hold busrq_n=0 until busak_n samples 0. No timeout.
  - On grant: dma_cs<=1, AD_DMA<=0, go to XFER.
- XFER:
  - One address per clk: AD_DMA increments 0..LEN-1.
  - After issuing LEN-1, AD_DMA holds at LEN-1 and the FSM goes to DRAIN.
  - dma_cs stays 1 throughout.
- Read pipeline:
  - An RDLY-deep shift register of {valid, addr} follows AD_DMA.
  - When a valid entry exits the pipeline: obj_we=1, obj_addr=the delayed address, obj_data=DD_DMA.
  - First write occurs RDLY+1 clks after dma_cs rises.
  - Exactly LEN writes, with addresses 0..LEN-1 ascending, no gaps and no repeats.
- DRAIN:
  - dma_cs held at 1 until the pipeline is empty (RDLY clks).
  - Then dma_cs<=0, busrq_n<=1, go to REL.
- REL:
  - Wait for busak_n==1.
  - Then INITEO<=0, dma_done pulses 1 clk, go to IDLE.
- Address width: counter is AW+1 bits internally so LEN=2^AW terminates without wrap. AD_DMA never wraps to 0 within a transfer.
- Grant withdrawn during XFER/DRAIN (busak_n returns 1): protocol violation. The block completes the copy anyway; the bench must flag it.
- VB edge on the same clk as the REL→IDLE transition: ignored, because the state is not IDLE on that edge.
- Reset mid-transfer: the block aborts immediately with busrq_n=1 and dma_cs=0. The object buffer may be partially written. The next VB edge restarts from address 0.
- Latency: from VB edge to busrq_n=0 is 1 clk. From grant to the last obj_we is LEN+RDLY clks.

Decomposition:
- Shared package jtpopeye_pkg holds:
  - state encoding constants IDLE/REQ/XFER/DRAIN/REL
  - the default LEN/AW values, also used by the object engine.
- One natural sub-module: jtpopeye_dma_pipe, the RDLY-deep {valid, addr} delay line, reusable for other registered-RAM readers.
- Everything else is a single FSM plus counter.

Test Plan:
- Basic copy:
  - Stimulus: LEN=16, RAM model with RDLY=2 preloaded with data=addr^8'h5A; VB pulse; grant after 7 cpu_cen.
  - Required: busrq_n low 1 clk after the edge; 16 obj_we pulses with obj_addr 0..15 and obj_data 5A,5B,58,...; busrq_n high 3 clks after AD_DMA reaches 15; dma_done pulses once after busak_n=1.
- Full size:
  - Stimulus: LEN=1024.
  - Required: last write at obj_addr=10'h3FF; AD_DMA never shows 0 after the first cycle; exactly 1024 writes.
- Delayed grant:
  - Stimulus: busak_n held high for 500 clks.
  - Required: busrq_n stays 0; dma_cs=0 and no obj_we during the wait; INITEO=1.
- VB during transfer:
  - Stimulus: second VB edge while in XFER.
  - Required: no restart; a single dma_done; next frame's VB edge starts a new copy from 0.
- Reset mid-XFER:
  - Stimulus: rst_n pulsed low at AD_DMA=0x123.
  - Required: busrq_n=1, dma_cs=0, obj_we=0 immediately; after release, the next VB edge begins at AD_DMA=0.
- Late bus release:
  - Stimulus: busak_n kept low 20 clks after busrq_n rises.
  - Required: INITEO stays 1 until busak_n=1; dma_done fires on the following clk.
